// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - load byte stream and instruction fetch bundle for imem_loader
//
// Groups the boot byte stream and the core's fetch port into one bundle.
//   ld_valid : a load byte is present           (master -> slave)
//   ld_data  : the load byte, 8 bits            (master -> slave)
//   ld_ready : the loader takes a byte now      (slave  -> master)
//   IR_addr  : byte address from the core's PC  (master -> slave)
//   IR       : instruction word to the core     (slave  -> master)
// master : boot source plus core fetch side; slave : imem_loader.
interface imem_loader_if;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic [31:0] IR_addr;
    logic [31:0] IR;

    modport master (
        output ld_valid,
        output ld_data,
        output IR_addr,
        input  ld_ready,
        input  IR
    );

    modport slave (
        input  ld_valid,
        input  ld_data,
        input  IR_addr,
        output ld_ready,
        output IR
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time instruction RAM loader and fetch port for the MIPS core
//
// After reset the core is held in reset while a big-endian byte stream
// (16-bit word count N, N 32-bit words, optional 32-bit checksum) is written
// into a word-addressed RAM. The loader then serves combinational fetches and
// releases the core. Oversized headers and bad checksums end in a terminal
// error state with the core still in reset.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds the CSUM state and a
// modulo-2^32 running sum of the data words that the trailer must match).
//
// Parameters:
//   DEPTH      : instruction words stored
//   AW         : word-index width, 2**AW >= DEPTH
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bus        : imem_loader_if.slave (ld_valid/ld_data/ld_ready, IR_addr/IR)
//   core_rst_n : active-low reset to the core, high only in RUN
//   boot_done  : program loaded and core running
//   boot_err   : load failed, core held in reset
module imem_loader #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.slave  bus,
    output logic          core_rst_n,
    output logic          boot_done,
    output logic          boot_err
);

    localparam logic [2:0] S_LEN_HI = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CSUM   = 3'd3;
    // The trailer follows the data words (or an empty program).
    localparam logic [2:0] S_AFTER_DATA = S_CSUM;
`else
    localparam logic [2:0] S_AFTER_DATA = S_RUN;
`endif

    logic [2:0]  state;
    logic [15:0] n_words;
    logic [AW:0] widx;      // one extra bit so that DEPTH itself is representable
    logic [1:0]  bcnt;      // byte position within the current 4-byte group
    logic [23:0] asm_q;     // first three bytes of the word being assembled
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] sum_q;
`endif

    logic [31:0] mem [0:DEPTH-1];

    logic        accept;
    logic [15:0] n_next;
    logic [31:0] word;
    logic        mem_we;
    logic        last_word;

    assign accept    = bus.ld_valid && bus.ld_ready;
    assign n_next    = {n_words[15:8], bus.ld_data};
    assign word      = {asm_q, bus.ld_data};
    assign mem_we    = accept && (state == S_DATA) && (bcnt == 2'd3);
    assign last_word = (32'(widx) + 32'd1) == 32'(n_words);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_LEN_HI;
            n_words <= 16'd0;
            widx    <= '0;
            bcnt    <= 2'd0;
            asm_q   <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= 32'd0;
`endif
        end else if (accept) begin
            case (state)
                S_LEN_HI: begin
                    n_words[15:8] <= bus.ld_data;
                    state         <= S_LEN_LO;
                end
                S_LEN_LO: begin
                    n_words[7:0] <= bus.ld_data;
                    if ({16'd0, n_next} > 32'(DEPTH))
                        state <= S_ERR;
                    else if (n_next == 16'd0)
                        state <= S_AFTER_DATA;
                    else
                        state <= S_DATA;
                end
                S_DATA: begin
                    asm_q <= {asm_q[15:0], bus.ld_data};
                    bcnt  <= bcnt + 2'd1;
                    if (bcnt == 2'd3) begin
                        widx <= widx + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_q <= sum_q + word;
`endif
                        if (last_word)
                            state <= S_AFTER_DATA;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    asm_q <= {asm_q[15:0], bus.ld_data};
                    bcnt  <= bcnt + 2'd1;
                    if (bcnt == 2'd3)
                        state <= (word == sum_q) ? S_RUN : S_ERR;
                end
`endif
                default: ;
            endcase
        end
    end

    // RAM is not reset; stale contents stay unreachable while N is 0.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[widx[AW-1:0]] <= word;
    end

    // Combinational fetch. Addresses past N, or with high bits set, read as a nop.
    logic [AW-1:0] fidx;
    logic          fetch_hit;
    logic          unused_addr_bits;

    assign fidx             = bus.IR_addr[AW+1:2];
    assign unused_addr_bits = ^bus.IR_addr[1:0];
    assign fetch_hit        = (state == S_RUN)
                           && (bus.IR_addr[31:AW+2] == '0)
                           && (32'(fidx) < 32'(n_words));
    assign bus.IR           = fetch_hit ? mem[fidx] : 32'h0;

    // Status outputs decode the state register only.
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign bus.ld_ready = (state == S_LEN_HI) || (state == S_LEN_LO)
                       || (state == S_DATA)   || (state == S_CSUM);
`else
    assign bus.ld_ready = (state == S_LEN_HI) || (state == S_LEN_LO)
                       || (state == S_DATA);
`endif
    assign core_rst_n = (state == S_RUN);
    assign boot_done  = (state == S_RUN);
    assign boot_err   = (state == S_ERR);

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction memory for the single-cycle MIPS core, sitting directly upstream of the core's instruction port. After reset it holds the core in reset while a byte stream is loaded into a word-addressed instruction RAM. It then serves the core's combinational instruction fetch (`IR_addr` to `IR`) and releases the core's reset. A length header, an optional checksum and an error state make program loading deterministic for benches and FPGA bring-up.

## Interface
- `DEPTH`, 256: instruction words stored.
- `AW`, 8: word-index width; `2**AW` must be at least `DEPTH`.
- `clk` input, 1: the single clock; all state updates on its rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `ld_valid` input, 1: a load byte is present.
- `ld_data` input, 8: the load byte.
- `ld_ready` output, 1: the loader accepts a byte this cycle.
- `IR_addr` input, 32: byte address from the core's PC.
- `IR` output, 32: instruction word to the core.
- `core_rst_n` output, 1: active-low reset to the core.
- `boot_done` output, 1: program loaded; core running.
- `boot_err` output, 1: load failed; core held in reset.

## Operation
- Byte accept: `ld_valid && ld_ready` at a rising edge. Bytes are never accepted in RUN or ERR.
- Stream format, all big-endian:
  - 16-bit word count N.
  - N words of 4 bytes each.
  - 32-bit checksum, only when the checksum feature is compiled in.
- FSM states: LEN_HI, LEN_LO, DATA, CSUM, RUN, ERR. Reset state is LEN_HI.
- Transitions:
  - LEN_HI: accept byte, load `N[15:8]`, go to LEN_LO.
  - LEN_LO: accept byte, load `N[7:0]`.
    - If N > `DEPTH`, go to ERR.
    - Else if N == 0, go to CSUM (feature on) or RUN (feature off).
    - Else go to DATA.
  - DATA: shift bytes into a 24-bit assembly register. On the 4th byte of a word, write `{asm, ld_data}` to `mem[widx]` at that edge and increment `widx`.
    - After word N-1 is written, go to CSUM (feature on) or RUN (feature off).
  - CSUM: accept 4 bytes. On the 4th byte, compare against the running sum.
    - Equal: go to RUN.
    - Not equal: go to ERR.
  - RUN and ERR: terminal; left only by `rst_n`.
- Fetch in RUN: index `i = IR_addr[AW+1:2]`.
  - `IR = mem[i]` when `IR_addr[31:AW+2] == 0` and `i < N`.
  - Otherwise `IR = 32'h0` (`sll $0,$0,0`, a nop).
- Fetch outside RUN: `IR = 32'h0`.
- `IR_addr[1:0]` is ignored.
- Output decode:
  - `ld_ready = 1` in LEN_HI, LEN_LO, DATA and CSUM; 0 otherwise.
  - `core_rst_n = 1` only in RUN.
  - `boot_done = 1` only in RUN.
  - `boot_err = 1` only in ERR.
  - All are decoded from the state register only, so they are glitch-free and have no combinational path from `ld_*`.
- Arithmetic:
  - `widx` is `AW+1` bits wide so that index `DEPTH` is representable.
  - The running sum is 32-bit modulo 2^32, clear at reset, and adds each completed word.

## Timing
- Reset values:
  - State LEN_HI; N, `widx`, byte counter, assembly register and sum are all 0.
  - Outputs: `ld_ready=1`, `core_rst_n=0`, `boot_done=0`, `boot_err=0`, `IR=0`.
  - RAM contents are not cleared. They are unreachable because N=0.
- Load throughput: one byte per cycle. A stall (`ld_valid=0`) holds all state.
- Write latency: each word is written at the edge that accepts its 4th byte. It is readable via `IR` from the edge it enters RUN.
- Core release: `core_rst_n` rises in the cycle right after the edge that accepts the final byte. The core's first active edge is the following one, with PC=0 fetching `mem[0]`.
- `IR` is combinational from `IR_addr` with zero latency, matching the core's single-cycle fetch.
- Reset mid-load (`rst_n` low in any state) returns immediately to the reset values. `core_rst_n` asserts asynchronously, and the partial program is discarded because N=0.
- N == `DEPTH` is legal. N == `DEPTH`+1 goes to ERR on the LEN_LO edge, with no RAM write.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - CSUM state exists.
  - A 4-byte checksum is required after the data words.
  - A mismatch goes to ERR.
- Not defined:
  - No CSUM state and no sum register.
  - The last data byte, or LEN_LO when N == 0, goes straight to RUN.

## Test plan
- Load N=2, words `32'h2008_0005`, `32'h2009_0007`, no stalls (checksum off). Required:
  - `core_rst_n` rises exactly 10 cycles after the first accepted byte.
  - `IR_addr=0` gives `IR=32'h2008_0005`.
  - `IR_addr=4` gives `32'h2009_0007`.
  - `IR_addr=8` gives `0`.
- Same stream with `ld_valid` deasserted for 3 cycles between bytes 4 and 5. Required: identical RAM contents, with RUN entered 3 cycles later.
- Checksum on, N=2 words as above:
  - With checksum `32'h4011_000C`: reaches RUN, `boot_done=1`.
  - With checksum `32'h4011_000D`: reaches ERR, `boot_err=1`, `core_rst_n=0`, `ld_ready=0`.
- Header N=257 (bytes `8'h01`, `8'h01`) with `DEPTH`=256. Required: ERR one edge after the second byte; further bytes are not accepted.
- `rst_n` pulsed low after 5 of 10 bytes, then a full reload of N=1 `32'hDEAD_BEEF`. Required:
  - Outputs return to reset values during the pulse.
  - After reload, `IR_addr=0` gives `IR=32'hDEAD_BEEF` and `IR_addr=4` gives `0`.
- In RUN, `IR_addr=32'h0000_0400` (beyond `DEPTH`). Required: `IR=0`, and the bench checks that no X propagates.
